// File: rtl/tick_sched_pkg.sv
// Shared defaults and config-FSM state type for the tick scheduler.
package tick_sched_pkg;

  localparam int unsigned CNT_W_DEF = 11;
  localparam int unsigned N_REQ_DEF = 4;
  localparam logic [CNT_W_DEF-1:0] DIV_RST_DEF = 11'd10;

  typedef enum logic [0:0] {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/tick_scheduler_rr_arbiter.sv
// Round-robin requester selection; the pointer advances only when a grant is issued.
module rr_arbiter
  import tick_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant_c
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] idx;
  logic             hit;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    grant_c = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    hit     = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = PTR_W'((32'(ptr_q) + i) % N_REQ);
      if (!hit && req[idx]) begin
        hit          = 1'b1;
        grant_c[idx] = 1'b1;
        ptr_d        = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PTR_W'(N_REQ - 1);
    end else if (sample) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Programmable tick divider with glitch-free divisor update and round-robin tick grants.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter int unsigned      N_REQ   = N_REQ_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RST_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             div_we_i,
  output logic             div_ack_o,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             tick_o,
  output logic             clk_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_d;
  logic [CNT_W-1:0] div_pend_q;
  logic [CNT_W-1:0] div_pend_d;
  cfg_state_t       state_q;
  cfg_state_t       state_d;
  logic             ack_d;
  logic             apply;
  logic             terminal;
  logic [N_REQ-1:0] grant_c;

  assign terminal = en_i && (cnt_q == div_q);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .sample  (terminal),
    .req     (req_i),
    .grant_c (grant_c)
  );

  // Divider datapath and registered tick/clock/grant outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      tick_o  <= 1'b0;
      clk_o   <= 1'b0;
      grant_o <= '0;
    end else begin
      cnt_q   <= (en_i && !terminal) ? cnt_q + CNT_W'(1) : '0;
      tick_o  <= terminal;
      grant_o <= terminal ? grant_c : '0;
      if (terminal) begin
        clk_o <= ~clk_o;
      end
    end
  end

  // Pending divisor lands on a period boundary, or immediately while stopped.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    div_pend_d = div_pend_q;
    ack_d      = 1'b0;
    apply      = (state_q == CFG_PENDING) && (terminal || !en_i);
    if (apply) begin
      div_d   = div_pend_q;
      ack_d   = 1'b1;
      state_d = CFG_IDLE;
    end
    if (div_we_i) begin
      div_pend_d = div_i;
      state_d    = CFG_PENDING;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CFG_IDLE;
      div_q      <= DIV_RST;
      div_pend_q <= '0;
      div_ack_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_pend_q <= div_pend_d;
      div_ack_o  <= ack_d;
    end
  end

endmodule
